// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus driver: FSM states, command
// codes and default timing (in clock cycles at 50 MHz).
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_E_HIGH,
        S_HOLD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    localparam int DEF_T_AS        = 2;
    localparam int DEF_T_EH        = 12;
    localparam int DEF_T_AH        = 2;
    localparam int DEF_T_WAIT      = 2000;
    localparam int DEF_T_WAIT_LONG = 82000;
    localparam int DEF_TW          = 18;

    // Clear and home are the slow instructions on this controller family.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Controller <-> LCD driver handshake plus the upstream byte-select mux path.
// The controller side is the master; the bus driver is the slave.
interface lcd_bus_driver_if;

    logic       lcd_enable;
    logic       reg_sel;
    logic [1:0] lcd_cnt;
    logic [7:0] lcd_data;
    logic [1:0] byte_idx;
    logic       busy;
    logic       lcd_finish;

    modport master (
        output lcd_enable, reg_sel, lcd_cnt, lcd_data,
        input  byte_idx, busy, lcd_finish
    );

    modport slave (
        input  lcd_enable, reg_sel, lcd_cnt, lcd_data,
        output byte_idx, busy, lcd_finish
    );

endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used to time each FSM phase; a phase loaded with N-1
// lasts exactly N cycles, ending in the cycle where zero is high.
module lcd_delay_cnt #(
    parameter int TW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// Writes lcd_cnt+1 bytes to an HD44780-style panel per lcd_enable request,
// sequencing setup, E pulse, hold and execution wait for every byte.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_AS        = DEF_T_AS,
    parameter int T_EH        = DEF_T_EH,
    parameter int T_AH        = DEF_T_AH,
    parameter int T_WAIT      = DEF_T_WAIT,
    parameter int T_WAIT_LONG = DEF_T_WAIT_LONG,
    parameter int TW          = DEF_TW
) (
    input  logic                clk,
    input  logic                rst,
    lcd_bus_driver_if.slave     bus,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [7:0]          lcd_db
);

    state_t        state, next_state;
    logic          rs_l;
    logic [1:0]    cnt_l;
    logic          long_l;
    logic [1:0]    byte_idx;
    logic          finish_r;
    logic          cnt_load;
    logic [TW-1:0] cnt_val;
    logic          cnt_zero;

    lcd_delay_cnt #(.TW(TW)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            S_IDLE: if (bus.lcd_enable) next_state = S_LOAD;
            S_LOAD: begin
                next_state = S_SETUP;
                cnt_load   = 1'b1;
                cnt_val    = TW'(T_AS - 1);
            end
            S_SETUP: if (cnt_zero) begin
                next_state = S_E_HIGH;
                cnt_load   = 1'b1;
                cnt_val    = TW'(T_EH - 1);
            end
            S_E_HIGH: if (cnt_zero) begin
                next_state = S_HOLD;
                cnt_load   = 1'b1;
                cnt_val    = TW'(T_AH - 1);
            end
            S_HOLD: if (cnt_zero) begin
                next_state = S_WAIT;
                cnt_load   = 1'b1;
                cnt_val    = long_l ? TW'(T_WAIT_LONG - 1) : TW'(T_WAIT - 1);
            end
            S_WAIT: if (cnt_zero) next_state = (byte_idx == cnt_l) ? S_DONE : S_LOAD;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Panel pins and the finish pulse are registered; finish therefore rises
    // on the edge that leaves DONE, coinciding with busy falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_l     <= 1'b0;
            cnt_l    <= 2'd0;
            long_l   <= 1'b0;
            byte_idx <= 2'd0;
            finish_r <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= 8'h00;
        end else begin
            lcd_e    <= (next_state == S_E_HIGH);
            finish_r <= (state == S_DONE);
            case (state)
                S_IDLE: if (bus.lcd_enable) begin
                    rs_l     <= bus.reg_sel;
                    cnt_l    <= bus.lcd_cnt;
                    byte_idx <= 2'd0;
                end
                S_LOAD: begin
                    lcd_db <= bus.lcd_data;
                    lcd_rs <= rs_l;
                    long_l <= is_long_cmd(rs_l, bus.lcd_data);
                end
                S_WAIT: if (cnt_zero && byte_idx != cnt_l) byte_idx <= byte_idx + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.byte_idx   = byte_idx;
    assign bus.busy       = (state != S_IDLE);
    assign bus.lcd_finish = finish_r;
    assign lcd_rw         = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver: directed and random transfers compared
// against a cycle-count model derived from the per-byte timing rules.
module tb_lcd_bus_driver;

    localparam int T_AS        = 2;
    localparam int T_EH        = 4;
    localparam int T_AH        = 2;
    localparam int T_WAIT      = 8;
    localparam int T_WAIT_LONG = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;
    logic [7:0] data_tab [4];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;

    lcd_bus_driver_if bus ();

    lcd_bus_driver #(
        .T_AS(T_AS), .T_EH(T_EH), .T_AH(T_AH),
        .T_WAIT(T_WAIT), .T_WAIT_LONG(T_WAIT_LONG), .TW(18)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    // Upstream byte mux: combinational lookup on byte_idx.
    assign bus.lcd_data = data_tab[bus.byte_idx];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records E pulses and finish pulses, sampled on the falling edge.
    int         rise_cyc[$];
    logic [7:0] rise_db[$];
    logic       rise_rs[$];
    int         width_q[$];
    int         fin_q[$];
    logic       fin_busy[$];
    logic       fin_prev_busy[$];
    logic       prev_e = 1'b0;
    logic       prev_busy = 1'b0;
    int         hi_cnt = 0;

    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            rise_cyc.push_back(cyc);
            rise_db.push_back(lcd_db);
            rise_rs.push_back(lcd_rs);
            hi_cnt <= 1;
        end else if (lcd_e) begin
            hi_cnt <= hi_cnt + 1;
        end
        if (!lcd_e && prev_e) width_q.push_back(hi_cnt);
        if (bus.lcd_finish) begin
            fin_q.push_back(cyc);
            fin_busy.push_back(bus.busy);
            fin_prev_busy.push_back(prev_busy);
        end
        prev_e    <= lcd_e;
        prev_busy <= bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cyc.delete(); rise_db.delete(); rise_rs.delete(); width_q.delete();
        fin_q.delete(); fin_busy.delete(); fin_prev_busy.delete();
    endtask

    // inject: 0 none, 1 enable pulse mid-transfer, 2 enable pulse during DONE.
    // plan_lat: latency from the test plan (0 = no fixed figure for this case).
    task automatic run_xfer(input string name, input logic rs, input logic [1:0] cnt,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input int inject, input int plan_lat, input bit quiet);
        int k, off, w, budget, nb;
        int exp_rise[4];
        data_tab[0] = d0; data_tab[1] = d1; data_tab[2] = d2; data_tab[3] = d3;
        clear_mon();
        @(negedge clk);
        bus.lcd_enable = 1'b1;
        bus.reg_sel    = rs;
        bus.lcd_cnt    = cnt;
        @(posedge clk); #1;
        k = cyc;
        // Inputs change after the start edge; the transfer must ignore this.
        bus.lcd_enable = 1'b0;
        bus.reg_sel    = ~rs;
        bus.lcd_cnt    = cnt + 2'($urandom_range(1, 3));

        // Reference model: byte i rises E at its LOAD + 1 + T_AS; each byte
        // costs 1 + T_AS + T_EH + T_AH + wait; finish one cycle after the sum.
        off = 0;
        nb  = int'(cnt) + 1;
        for (int i = 0; i < nb; i++) begin
            w = (!rs && data_tab[i] >= 8'd1 && data_tab[i] <= 8'd3) ? T_WAIT_LONG : T_WAIT;
            exp_rise[i] = off + 1 + T_AS;
            off += 1 + T_AS + T_EH + T_AH + w;
        end

        budget = 0;
        while (fin_q.size() == 0 && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
            bus.lcd_enable = 1'b0;
            if (inject == 1 && cyc == k + 6)   bus.lcd_enable = 1'b1;
            if (inject == 2 && cyc == k + off) bus.lcd_enable = 1'b1;
        end
        bus.lcd_enable = 1'b0;
        check({name, ".finished"}, fin_q.size() > 0, 1'b1);
        if (quiet) repeat (40) @(posedge clk);

        check({name, ".n_bytes"}, rise_cyc.size(), nb);
        for (int i = 0; i < nb && i < rise_cyc.size(); i++) begin
            check($sformatf("%s.db%0d", name, i), rise_db[i], data_tab[i]);
            check($sformatf("%s.rs%0d", name, i), rise_rs[i], rs);
            check($sformatf("%s.e_rise%0d", name, i), rise_cyc[i] - k, exp_rise[i]);
            if (i < width_q.size())
                check($sformatf("%s.e_width%0d", name, i), width_q[i], T_EH);
        end
        check({name, ".n_finish"}, fin_q.size(), 1);
        if (fin_q.size() > 0) begin
            check({name, ".finish_lat"}, fin_q[0] - k, off + 1);
            if (plan_lat != 0) check({name, ".finish_plan"}, fin_q[0] - k, plan_lat);
            check({name, ".busy_at_finish"}, fin_busy[0], 1'b0);
            check({name, ".busy_before_finish"}, fin_prev_busy[0], 1'b1);
        end
    endtask

    initial begin
        int budget;
        logic       r_rs;
        logic [1:0] r_cnt;
        logic [7:0] r_d [4];

        bus.lcd_enable = 1'b0;
        bus.reg_sel    = 1'b0;
        bus.lcd_cnt    = 2'd0;
        for (int i = 0; i < 4; i++) data_tab[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset.lcd_e", lcd_e, 1'b0);
        check("reset.lcd_rs", lcd_rs, 1'b0);
        check("reset.lcd_db", lcd_db, 8'h00);
        check("reset.byte_idx", bus.byte_idx, 2'd0);
        check("reset.finish", bus.lcd_finish, 1'b0);
        check("reset.busy", bus.busy, 1'b0);
        check("reset.lcd_rw", lcd_rw, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_xfer("single", 1'b0, 2'd0, 8'h80, 8'h00, 8'h00, 8'h00, 0, 18, 1'b0);
        run_xfer("four_data", 1'b1, 2'd3, 8'h30, 8'h31, 8'h32, 8'h33, 0, 69, 1'b0);
        run_xfer("long_cmd", 1'b0, 2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 30, 1'b0);
        run_xfer("clr_as_data", 1'b1, 2'd0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 18, 1'b0);
        run_xfer("back_to_back", 1'b0, 2'd2, 8'h02, 8'h03, 8'h38, 8'h00, 0, 0, 1'b0);
        run_xfer("enable_mid", 1'b1, 2'd2, 8'hA5, 8'h5A, 8'hFF, 8'h00, 1, 0, 1'b1);
        run_xfer("enable_done", 1'b0, 2'd1, 8'h0C, 8'h06, 8'h00, 8'h00, 2, 0, 1'b1);

        // Reset during the E pulse aborts the transfer at once.
        clear_mon();
        data_tab[0] = 8'h55; data_tab[1] = 8'hAA;
        @(negedge clk);
        bus.lcd_enable = 1'b1; bus.reg_sel = 1'b1; bus.lcd_cnt = 2'd1;
        @(negedge clk);
        bus.lcd_enable = 1'b0;
        budget = 0;
        while (!lcd_e && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("rst_mid.reached_e_high", lcd_e, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.lcd_e", lcd_e, 1'b0);
        check("rst_mid.lcd_db", lcd_db, 8'h00);
        check("rst_mid.busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        check("rst_mid.no_finish", fin_q.size(), 0);
        run_xfer("after_reset", 1'b1, 2'd1, 8'h48, 8'h69, 8'h00, 8'h00, 0, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            r_rs  = 1'($urandom_range(0, 1));
            r_cnt = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++)
                r_d[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            run_xfer($sformatf("rand%0d", t), r_rs, r_cnt, r_d[0], r_d[1], r_d[2], r_d[3],
                     0, 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_bus_driver.md
Name: lcd_bus_driver

Overview:
- Responder side of the controller↔LCD handshake: accepts a one-cycle `lcd_enable` request carrying `reg_sel` and `lcd_cnt`, then writes `lcd_cnt`+1 bytes to an HD44780-style panel over an 8-bit parallel bus.
- Generates setup, E-pulse, hold and busy-wait timing per byte, then returns a one-cycle `lcd_finish`.
- Byte data is fetched from an upstream mux indexed by `byte_idx`.

Parameters:
- T_AS, 2: cycles from bus valid (`lcd_db`/`lcd_rs`) to `lcd_e` rise.
- T_EH, 12: cycles `lcd_e` is held high.
- T_AH, 2: cycles the bus is held after `lcd_e` falls.
- T_WAIT, 2000: execution wait per normal byte (40 µs @ 50 MHz).
- T_WAIT_LONG, 82000: execution wait after clear/home commands (1.64 ms @ 50 MHz).
- TW, 18: width of the delay counter; must hold T_WAIT_LONG.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- lcd_enable  in  1  one-cycle start request; ignored unless in IDLE
- reg_sel  in  1  RS for the whole transfer; sampled with `lcd_enable`
- lcd_cnt  in  2  index of the last byte; transfer length = `lcd_cnt`+1; sampled with `lcd_enable`
- lcd_data  in  8  byte selected upstream by `byte_idx`
- byte_idx  out  2  index of the byte currently being fetched
- busy  out  1  high in every state except IDLE
- lcd_finish  out  1  one-cycle pulse when the transfer completes
- lcd_e  out  1  LCD enable pin (registered)
- lcd_rs  out  1  LCD RS pin (registered)
- lcd_rw  out  1  tied 0 (write-only)
- lcd_db  out  8  LCD data pins (registered)

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - `lcd_e`, `lcd_rs`, `lcd_db`, `byte_idx`, `lcd_finish`, `busy` all 0.
  - Delay counter 0.
  - Reset mid-transfer aborts with no `lcd_finish` and `lcd_e` dropped at once.
- States: IDLE, LOAD, SETUP, E_HIGH, HOLD, WAIT, DONE.
- IDLE:
  - On `lcd_enable`=1 at edge k: latch `rs_l`<=`reg_sel`, `cnt_l`<=`lcd_cnt`; `byte_idx`<=0; go to LOAD.
  - `lcd_enable` in any other state is ignored (no queueing).
- LOAD, one cycle:
  - `lcd_db`<=`lcd_data`, `lcd_rs`<=`rs_l`.
  - Decide the wait length: long if `rs_l`=0 and `lcd_data` ∈ {0x01, 0x02, 0x03}, else normal.
  - Go to SETUP.
  - Upstream must present `lcd_data` for the new `byte_idx` combinationally within that cycle.
- SETUP: T_AS cycles, `lcd_e`=0.
- E_HIGH: T_EH cycles, `lcd_e`=1.
- HOLD: T_AH cycles, `lcd_e`=0, bus unchanged.
- WAIT: T_WAIT or T_WAIT_LONG cycles, bus unchanged.
- End of WAIT:
  - If `byte_idx`==`cnt_l`, go to DONE.
  - Else `byte_idx`<=`byte_idx`+1 and go to LOAD. No wrap: `cnt_l`≤3 bounds the index.
- DONE, one cycle: `lcd_finish`=1, then IDLE.
  - The controller may reissue `lcd_enable` on the very next cycle; IDLE must accept it.
- Latency:
  - Per byte P = 1+T_AS+T_EH+T_AH+W.
  - `lcd_finish` is high in the cycle beginning at edge k+1+Σ P over all bytes.
- Simultaneous events:
  - `lcd_enable` during DONE is dropped.
  - `reg_sel`/`lcd_cnt` changes after edge k do not affect the transfer.
- Delay counter: loaded with N-1 on state entry, counts down, state advances when counter==0. Each timed state lasts exactly N cycles.
- Parameter constraint: every T_* ≥ 1.
- `lcd_db` and `lcd_rs` are stable from LOAD exit until the next LOAD.

Decomposition:
- Shared package `lcd_pkg`:
  - State encoding constants.
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02.
  - Default timing constants reused by the controller and test bench.
- One natural sub-module `lcd_delay_cnt`:
  - Inputs `load`, `load_val[TW-1:0]`.
  - Output `zero`.
  - Down-counter; async active-high reset on `rst`.

Test Plan (T_AS=2, T_EH=4, T_AH=2, T_WAIT=8, T_WAIT_LONG=20):
- Single byte: `lcd_enable` with `reg_sel`=0, `lcd_cnt`=0, `lcd_data`=8'h80 → `lcd_db`=8'h80 and `lcd_rs`=0; `lcd_e` high exactly 4 cycles starting 3 cycles after LOAD; `lcd_finish` pulses exactly 18 cycles after the start edge; `busy` falls with it.
- Four data bytes: `reg_sel`=1, `lcd_cnt`=3, upstream returns 8'h30+`byte_idx` → four E pulses carrying 0x30, 0x31, 0x32, 0x33 with `lcd_rs`=1; `lcd_finish` exactly 69 cycles after the start edge.
- Long command: `reg_sel`=0, `lcd_data`=8'h01 → WAIT lasts 20 cycles, `lcd_finish` at 30 cycles. The same byte with `reg_sel`=1 uses a normal 8-cycle wait.
- Back-to-back: reissue `lcd_enable` the cycle after `lcd_finish` → new transfer accepted. `lcd_enable` pulsed mid-transfer → ignored, exactly one `lcd_finish`.
- Reset while in E_HIGH → `lcd_e`, `lcd_db`, `busy` 0 immediately; no `lcd_finish`; a subsequent request completes normally.
- Input hold: toggle `reg_sel`/`lcd_cnt` after the start edge → the transfer uses the latched values (byte count and RS unchanged).
